i2c_master_seq: RTL
===================

// Module: i2c_master_seq
// PURPOSE
//  Single-byte I2C bus master sequencer. Generates START, 7-bit address + R/W, slave ACK check,
//  one data byte (write or read), ACK/NACK and STOP on scl_o/sda_o.
//  Drives the SDA/SCL pattern that the team's I2C pattern-detector FSMs monitor.
//  Sits between a host command port and the open-drain pad cells.
// PARAMETERS
//  CLK_DIV  4  clk cycles per SCL quarter-period (legal >= 2); SCL period = 4*CLK_DIV clk
// PORTS
//  clk      in   1  system clock, rising edge
//  reset    in   1  reset, synchronous, active-high
//  start    in   1  command request; sampled only when busy=0
//  addr     in   7  slave address, latched on accept
//  rw       in   1  0=write, 1=read; latched on accept
//  wdata    in   8  write byte, latched on accept
//  sda_i    in   1  SDA pad input (already synchronised)
//  scl_o    out  1  SCL level (1 = released)
//  sda_o    out  1  SDA level (1 = released)
//  busy     out  1  transaction in progress
//  done     out  1  one-cycle pulse at transaction end
//  ack_err  out  1  set with done if address or write-data NACKed; held until next accept
//  rdata    out  8  read byte, valid from done (rw=1, ack_err=0) until next accept
// BEHAVIOUR
//  Reset: scl_o=1, sda_o=1, busy=0, done=0, ack_err=0, rdata=0, state IDLE, divider/phase=0.
//  Reset mid-transaction: aborts next edge to reset values; no STOP generated, no done.
//  Accept: IDLE & start=1 -> latch {addr,rw,wdata}, clear ack_err, busy=1 next cycle.
//  start while busy ignored (no queueing).
//  Divider: counter 0..CLK_DIV-1; qtick when counter==CLK_DIV-1; phase 0..3 advances on qtick.
//  Counter and phase both restart at 0 on accept.
//  States: IDLE, START, ADDR(8 bits), ACK1, DATA(8 bits), ACK2, STOP; one bit = phases 0..3.
//  START: ph0 sda=1 scl=1; ph1 sda=0 scl=1; ph2-3 sda=0 scl=0 -> ADDR.
//  Data bit (ADDR/DATA): sda set in ph0 with scl=0; scl=1 in ph1-2; scl=0 in ph3. MSB first.
//  ADDR shifts {addr,rw}.
//  DATA, rw=0: drive wdata. rw=1: sda=1 (released), sample sda_i on qtick ending ph1, shift into rdata.
//  ACK1: sda released; sample sda_i at end of ph1. 1 -> ack_err=1 -> STOP; 0 -> DATA.
//  ACK2, rw=0: sample slave ACK as in ACK1, NACK sets ack_err.
//  ACK2, rw=1: master drives NACK (sda=1). Both cases -> STOP.
//  STOP: ph0 sda=0 scl=0; ph1 sda=0 scl=1; ph2-3 sda=1 scl=1.
//  On qtick ending STOP ph3: done=1 one cycle, busy=0 same cycle, -> IDLE.
//  SDA never changes while scl=1 except in START ph1 and STOP ph2.
//  Latency accept->done:
//    full transaction: 20 bit periods = 80*CLK_DIV clk.
//    address NACK: 11 bit periods = 44*CLK_DIV clk.
//  start=1 in the done cycle is accepted (back-to-back allowed; busy low only that cycle).
//  Clock stretching and arbitration loss are not supported; sda_i is used only for ACK and read sampling.
// STRUCTURE
//  Package i2c_pkg: state encoding localparams (IDLE..STOP), phase constants PH0..PH3, BITS_PER_BYTE=8.
//  Sub-module i2c_qtick_gen (CLK_DIV counter + 2-bit phase, sync clear on accept).
//  Top level holds the FSM, bit counter (0..7), shift registers, and output regs (all registered).
// TESTING  (CLK_DIV=4; slave model ACKs unless stated)
//  1 Write addr=7'h50 wdata=8'hA5 -> SDA bits 1010000_0, ack, 10100101, ack;
//    done at +320 clk, ack_err=0.
//  2 Read addr=7'h21 with slave returning 8'h3C -> rdata=8'h3C, master NACK in ACK2,
//    done at +320 clk.
//  3 Slave NACKs address -> ack_err=1, STOP issued, no DATA bits, done at +176 clk.
//  4 start pulsed while busy, then start in the done cycle -> first ignored,
//    second accepted, busy re-asserts next cycle.
//  5 reset asserted mid-DATA -> next edge scl_o=sda_o=1, busy=0, no done;
//    a new start then runs normally.
//  6 Protocol checker across all tests: SDA transitions while SCL=1 only at START/STOP;
//    SCL high/low each 2*CLK_DIV clk.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master sequencer.
// bus_levels() maps a sequencer position to the {scl, sda} pad levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK1,
    ST_DATA,
    ST_ACK2,
    ST_STOP
  } i2c_state_e;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  localparam int unsigned BITS_PER_BYTE = 8;

  // Returns {scl, sda}; 1 means released. Bit slots hold SCL high in ph1-2 only.
  function automatic logic [1:0] bus_levels(input i2c_state_e st,
                                            input logic [1:0] ph,
                                            input logic       bit_val,
                                            input logic       rd);
    logic       scl_bit;
    logic [1:0] lv;
    scl_bit = (ph == PH1) || (ph == PH2);
    lv      = 2'b11;
    case (st)
      ST_START: begin
        if (ph == PH0)      lv = 2'b11;
        else if (ph == PH1) lv = 2'b10;
        else                lv = 2'b00;
      end
      ST_ADDR:          lv = {scl_bit, bit_val};
      ST_DATA:          lv = {scl_bit, rd | bit_val};
      ST_ACK1, ST_ACK2: lv = {scl_bit, 1'b1};
      ST_STOP: begin
        if (ph == PH0)      lv = 2'b00;
        else if (ph == PH1) lv = 2'b10;
        else                lv = 2'b11;
      end
      default:          lv = 2'b11;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// SCL quarter-period tick generator: CLK_DIV-cycle counter plus 2-bit phase.
// Both restart at 0 on clr_i; phase_nxt_o lets the parent register outputs in step.
module i2c_qtick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  output logic       qtick_o,
  output logic [1:0] phase_o,
  output logic [1:0] phase_nxt_o
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  assign qtick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (en_i) begin
      if (qtick_o) begin
        cnt_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o     = phase_q;
  assign phase_nxt_o = phase_d;

endmodule

// File: rtl/i2c_master_seq.sv
// Single-byte I2C master: START, address+R/W, ACK check, one data byte, ACK/NACK, STOP.
// All outputs are registered; pad levels are decoded from the next-state values.
module i2c_master_seq #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  import i2c_pkg::*;

  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

  i2c_state_e state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rw_q, rw_d;
  logic       nack_q, nack_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ack_err_q, ack_err_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;

  logic       accept;
  logic       qtick;
  logic       end_ph1;
  logic       end_ph3;
  logic [1:0] phase_q;
  logic [1:0] phase_nxt;

  assign accept  = (state_q == ST_IDLE) && start;
  assign end_ph1 = qtick && (phase_q == PH1);
  assign end_ph3 = qtick && (phase_q == PH3);

  i2c_qtick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_qtick (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (accept),
    .en_i       (busy_q),
    .qtick_o    (qtick),
    .phase_o    (phase_q),
    .phase_nxt_o(phase_nxt)
  );

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rw_d      = rw_q;
    nack_d    = nack_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_START;
          busy_d    = 1'b1;
          tx_d      = {addr, rw};
          rw_d      = rw;
          wdata_d   = wdata;
          nack_d    = 1'b0;
          ack_err_d = 1'b0;
          bit_d     = '0;
        end
      end
      ST_START: begin
        if (end_ph3) begin
          state_d = ST_ADDR;
          bit_d   = '0;
        end
      end
      ST_ADDR: begin
        if (end_ph3) begin
          if (bit_q == LAST_BIT) begin
            state_d = ST_ACK1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end
      end
      ST_ACK1: begin
        if (end_ph1) nack_d = sda_i;
        if (end_ph3) begin
          if (nack_q) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
            bit_d   = '0;
            tx_d    = wdata_q;
          end
        end
      end
      ST_DATA: begin
        // Read bits are captured mid-high (end of ph1), well clear of SCL edges.
        if (end_ph1 && rw_q) rx_d = {rx_q[6:0], sda_i};
        if (end_ph3) begin
          if (bit_q == LAST_BIT) begin
            state_d = ST_ACK2;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end
      end
      ST_ACK2: begin
        if (end_ph1 && !rw_q) nack_d = sda_i;
        if (end_ph3) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (end_ph3) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          ack_err_d = nack_q;
          if (rw_q && !nack_q) rdata_d = rx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    {scl_d, sda_d} = bus_levels(state_d, phase_nxt, tx_d[7], rw_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rw_q      <= 1'b0;
      nack_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rw_q      <= rw_d;
      nack_q    <= nack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
    end
  end

  assign scl_o   = scl_q;
  assign sda_o   = sda_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

endmodule
